oldland_write_buffer: RTL and testbench
=======================================

OLDLAND_WRITE_BUFFER -- requirements
Module: oldland_write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of posted-write entries; power of two, 2..16.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 c_access  in  1  cache-side request, held until c_ack.
REQ-005 c_addr  in  30  cache-side word address.
REQ-006 c_wr_val  in  32  cache-side write data.
REQ-007 c_wr_en  in  1  1 = write, 0 = read.
REQ-008 c_bytesel  in  4  cache-side byte enables.
REQ-009 c_data  out  32  read data; valid only while c_ack=1, else 0.
REQ-010 c_ack  out  1  one-cycle completion pulse to the cache.
REQ-011 c_error  out  1  read error; asserted only together with c_ack.
REQ-012 m_access, m_addr[29:0], m_wr_val[31:0], m_wr_en, m_bytesel[3:0]  out  memory-side request, held stable until m_ack or m_error.
REQ-013 m_data  in  32, m_ack  in  1, m_error  in  1  memory-side response.
REQ-014 wb_empty  out  1  no buffered writes and no memory transaction in flight.
REQ-015 wb_error  out  1  sticky: a posted write received m_error.
REQ-016 err_clr  in  1  clears wb_error.

Function
REQ-017 Entry = {addr[29:0], data[31:0], bytesel[3:0]}, 66 bits; FIFO order is strict, with no merging and no forwarding.
REQ-018 Write accept: in IDLE with c_access=1, c_wr_en=1 and (count<DEPTH, or count==DEPTH with a pop in the same cycle), the entry is enqueued at that edge and c_ack pulses the next cycle.
REQ-019 Write while full with no pop: the request stalls with no c_ack, and is accepted at the first edge a slot exists.
REQ-020 Read: a read SHALL NOT issue to memory until the FIFO is empty and no write is in flight; it then drives m_access with m_wr_en=0 and the request's addr/bytesel.
REQ-021 Read completion: on m_ack, m_data is registered; the next cycle c_ack=1 and c_data=registered value. On m_error, the next cycle c_ack=1, c_error=1 and c_data=0.
REQ-022 Cache-side FSM states: IDLE, RD_DRAIN (waiting for empty), RD_MEM (read outstanding), RESP (one-cycle c_ack); RESP always returns to IDLE.
REQ-023 Drain engine: when the FIFO is non-empty and no read is outstanding, the head entry is presented with m_wr_en=1 and popped at the edge where m_ack or m_error is sampled; the next head may be presented the following cycle.
REQ-024 Posted-write m_error: the entry is popped (dropped) and wb_error is set; the error is not reported on c_error.
REQ-025 err_clr and a new error in the same cycle: wb_error remains 1.
REQ-026 m_access SHALL deassert the cycle after m_ack/m_error unless another transaction is immediately presented.
REQ-027 Count arithmetic: width is log2(DEPTH)+1. Push and pop in the same cycle leave count unchanged. Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-028 wb_empty = (count==0) & ~m_access, registered-equivalent.
REQ-029 c_bytesel=0000 writes are buffered and issued unchanged.
REQ-030 Memory-side transactions are never issued back-to-back in the same cycle as a response.

Reset
REQ-031 rst_n=0 asynchronously clears count, pointers, the FSM (to IDLE), the drain engine, wb_error, and every output to 0; buffered entries are discarded.
REQ-032 Reset mid-transaction abandons the transaction with no c_ack. Deassertion is synchronized to clk externally; operation resumes the first edge after release.

Structure
REQ-033 Package oldland_wb_pkg SHALL hold the FSM state encoding, the entry-width constant (66) and field offsets.
REQ-034 FIFO storage and pointers SHALL be a sub-module oldland_wb_fifo (push, pop, full, empty, count, head data); the FSM and drain engine live in oldland_write_buffer.

Verification
REQ-035 Write 0x0000_0100 <- 0xDEADBEEF, bytesel 1111, memory acks after 3 cycles -> c_ack the cycle after accept; m_* shows the same addr/data; wb_empty=1 after m_ack.
REQ-036 DEPTH=4, memory stalled: 5 writes -> 4 c_acks; the 5th acks the cycle after the first m_ack; memory order is entries 1..5.
REQ-037 Two writes buffered, then a read of 0x40 returning 0x12345678 -> the read is issued only after both write m_acks; c_data=0x12345678 with c_ack one cycle after the read m_ack.
REQ-038 Posted write gets m_error -> wb_error=1, no c_error, next entry drains; err_clr -> wb_error=0.
REQ-039 Read gets m_error -> c_ack=1, c_error=1, c_data=0 for exactly one cycle.
REQ-040 rst_n low with 3 entries buffered and one write in flight -> all outputs 0 immediately; after release wb_empty=1 and no m_access.

Source files
------------

// File: rtl/oldland_wb_pkg.sv
// Shared types for the oldland posted-write buffer.
// Holds the cache-side FSM encoding, the 66-bit entry layout and its field offsets.
package oldland_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_DRAIN = 2'd1,
        ST_RD_MEM   = 2'd2,
        ST_RESP     = 2'd3
    } wb_state_t;

    localparam int ENTRY_W  = 66;
    localparam int BSEL_LSB = 0;
    localparam int BSEL_W   = 4;
    localparam int DATA_LSB = 4;
    localparam int DATA_W   = 32;
    localparam int ADDR_LSB = 36;
    localparam int ADDR_W   = 30;

    typedef logic [ENTRY_W-1:0] wb_entry_t;

    function automatic wb_entry_t pack_entry(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data,
        input logic [BSEL_W-1:0] bsel
    );
        return {addr, data, bsel};
    endfunction

endpackage

// File: rtl/oldland_wb_fifo.sv
// Strict-order storage for posted writes: one push and one pop per cycle.
// Ports: push/wdata in, pop in, head out, full/empty/count status out.
module oldland_wb_fifo
    import oldland_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  wb_entry_t        wdata,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts when the head leaves at the same edge.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/oldland_write_buffer.sv
// Posted-write buffer between the oldland cache and memory bus.
// Ports: c_* cache side, m_* memory side, wb_empty/wb_error status, err_clr.
module oldland_write_buffer
    import oldland_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        c_access,
    input  logic [29:0] c_addr,
    input  logic [31:0] c_wr_val,
    input  logic        c_wr_en,
    input  logic [3:0]  c_bytesel,
    output logic [31:0] c_data,
    output logic        c_ack,
    output logic        c_error,
    output logic        m_access,
    output logic [29:0] m_addr,
    output logic [31:0] m_wr_val,
    output logic        m_wr_en,
    output logic [3:0]  m_bytesel,
    input  logic [31:0] m_data,
    input  logic        m_ack,
    input  logic        m_error,
    output logic        wb_empty,
    output logic        wb_error,
    input  logic        err_clr
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_state_t        state;
    wb_state_t        state_nxt;
    wb_entry_t        head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nxt;
    logic             m_done;
    logic             push;
    logic             pop;
    logic             rd_done;
    logic             wr_issue;
    logic             rd_issue;
    logic             m_access_nxt;
    logic [31:0]      rsp_data;
    logic             rsp_err;

    assign m_done   = m_access & (m_ack | m_error);
    assign pop      = m_done & m_wr_en;
    assign rd_done  = m_done & ~m_wr_en;
    assign push     = (state == ST_IDLE) & c_access & c_wr_en
                    & (~full | pop);
    // New transactions only start from an idle bus, so a response
    // cycle is never also an issue cycle.
    assign wr_issue = ~m_access & ~empty;
    assign rd_issue = (state == ST_RD_DRAIN) & ~m_access & empty;

    assign m_access_nxt = m_done ? 1'b0 : (m_access | wr_issue | rd_issue);

    oldland_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pack_entry(c_addr, c_wr_val, c_bytesel)),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (c_access) begin
                    if (!c_wr_en)  state_nxt = ST_RD_DRAIN;
                    else if (push) state_nxt = ST_RESP;
                end
            end
            ST_RD_DRAIN: if (rd_issue) state_nxt = ST_RD_MEM;
            ST_RD_MEM:   if (rd_done)  state_nxt = ST_RESP;
            ST_RESP:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_access  <= 1'b0;
            m_addr    <= '0;
            m_wr_val  <= '0;
            m_wr_en   <= 1'b0;
            m_bytesel <= '0;
        end else begin
            m_access <= m_access_nxt;
            if (m_done) begin
                m_addr    <= '0;
                m_wr_val  <= '0;
                m_wr_en   <= 1'b0;
                m_bytesel <= '0;
            end else if (wr_issue) begin
                m_addr    <= head[ADDR_LSB +: ADDR_W];
                m_wr_val  <= head[DATA_LSB +: DATA_W];
                m_wr_en   <= 1'b1;
                m_bytesel <= head[BSEL_LSB +: BSEL_W];
            end else if (rd_issue) begin
                m_addr    <= c_addr;
                m_wr_val  <= '0;
                m_wr_en   <= 1'b0;
                m_bytesel <= c_bytesel;
            end
        end
    end

    always_comb begin
        cnt_nxt = count;
        if (push & ~pop)      cnt_nxt = count + CNT_W'(1);
        else if (pop & ~push) cnt_nxt = count - CNT_W'(1);
    end

    // A write's RESP must not reuse a stale read result, so the
    // response registers are cleared whenever a write is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            wb_error <= 1'b0;
            wb_empty <= 1'b0;
        end else begin
            if (rd_done) begin
                rsp_data <= m_error ? '0 : m_data;
                rsp_err  <= m_error;
            end else if (push) begin
                rsp_data <= '0;
                rsp_err  <= 1'b0;
            end
            if (pop & m_error) wb_error <= 1'b1;
            else if (err_clr)  wb_error <= 1'b0;
            wb_empty <= (cnt_nxt == '0) & ~m_access_nxt;
        end
    end

    assign c_ack   = (state == ST_RESP);
    assign c_data  = c_ack ? rsp_data : '0;
    assign c_error = c_ack & rsp_err;

endmodule

// File: tb/tb_oldland_write_buffer.sv
// Self-checking bench for oldland_write_buffer (DEPTH=4).
// Transaction-level model: expected memory order and cache responses.
module tb_oldland_write_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_access;
    logic [29:0] c_addr;
    logic [31:0] c_wr_val;
    logic        c_wr_en;
    logic [3:0]  c_bytesel;
    logic [31:0] c_data;
    logic        c_ack;
    logic        c_error;
    logic        m_access;
    logic [29:0] m_addr;
    logic [31:0] m_wr_val;
    logic        m_wr_en;
    logic [3:0]  m_bytesel;
    logic [31:0] m_data;
    logic        m_ack;
    logic        m_error;
    logic        wb_empty;
    logic        wb_error;
    logic        err_clr;

    oldland_write_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_access(c_access), .c_addr(c_addr), .c_wr_val(c_wr_val),
        .c_wr_en(c_wr_en), .c_bytesel(c_bytesel), .c_data(c_data),
        .c_ack(c_ack), .c_error(c_error),
        .m_access(m_access), .m_addr(m_addr), .m_wr_val(m_wr_val),
        .m_wr_en(m_wr_en), .m_bytesel(m_bytesel), .m_data(m_data),
        .m_ack(m_ack), .m_error(m_error),
        .wb_empty(wb_empty), .wb_error(wb_error), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  bsel;
        logic [31:0] rdata;
        logic        err;
        logic        clr;
    } tx_t;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    tx_t  exp_tx[$];
    rsp_t exp_rsp[$];
    int   mack_q[$];
    int   exp_rd = 0;
    int   rsp_rd = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ack_cnt = 0;
    int   wr_acked = 0;
    int   wr_done = 0;
    int   lat = 1;
    bit   stall = 1'b0;
    int   clr_req = 0;
    int   clr_seen = 0;
    int   rd_mack_cyc = 0;
    logic [29:0] last_addr;
    logic [31:0] last_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    // Memory responder: acks each transaction after lat cycles of m_access
    // and checks it against the expected memory order.
    initial begin
        int   wait_n;
        tx_t  t;
        wait_n  = 0;
        m_ack   = 1'b0;
        m_error = 1'b0;
        m_data  = '0;
        err_clr = 1'b0;
        forever begin
            @(negedge clk);
            m_ack   = 1'b0;
            m_error = 1'b0;
            m_data  = '0;
            err_clr = 1'b0;
            if (clr_req != clr_seen) begin
                err_clr  = 1'b1;
                clr_seen = clr_req;
            end
            if (!rst_n) begin
                exp_rd = exp_tx.size();
                wait_n = 0;
            end else if (m_access) begin
                wait_n++;
                if (!stall && wait_n >= lat) begin
                    wait_n = 0;
                    if (exp_rd >= exp_tx.size()) begin
                        fail("unexpected_m_access");
                        m_ack = 1'b1;
                    end else begin
                        t = exp_tx[exp_rd];
                        exp_rd++;
                        chk("m_wr_en", m_wr_en, t.wr);
                        chk("m_addr", m_addr, t.addr);
                        chk("m_wr_val", m_wr_val, t.data);
                        chk("m_bytesel", m_bytesel, t.bsel);
                        last_addr = m_addr;
                        last_data = m_wr_val;
                        mack_q.push_back(cyc);
                        if (!t.wr) rd_mack_cyc = cyc;
                        if (t.wr) wr_done++;
                        if (t.err) begin
                            m_error = 1'b1;
                            m_data  = 32'hBAD0_BAD0;
                        end else begin
                            m_ack  = 1'b1;
                            m_data = t.wr ? 32'h0 : t.rdata;
                        end
                        if (t.clr) err_clr = 1'b1;
                    end
                end
            end
        end
    end

    // Cache-side compare: every acked cycle against the response queue,
    // plus output-quiet and buffered-write invariants every cycle.
    initial begin
        logic prev_ack;
        rsp_t r;
        prev_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rsp_rd   = exp_rsp.size();
                wr_acked = wr_done;
                prev_ack = 1'b0;
            end else begin
                chk("c_error_without_ack", c_error & ~c_ack, 1'b0);
                if (!c_ack) begin
                    chk("c_data_idle", c_data, 32'h0);
                end else begin
                    chk("c_ack_width", prev_ack, 1'b0);
                    ack_cnt++;
                    if (rsp_rd >= exp_rsp.size()) begin
                        fail("unexpected_c_ack");
                    end else begin
                        r = exp_rsp[rsp_rd];
                        rsp_rd++;
                        chk("c_data", c_data, r.data);
                        chk("c_error", c_error, r.err);
                        if (r.wr) wr_acked++;
                    end
                end
                if (wb_empty) chk("wb_empty_pending", wr_acked - wr_done, 0);
                prev_ack = c_ack;
            end
        end
    end

    task automatic do_req(input logic wr, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] b,
                          input logic err, input logic clr,
                          output int lat_out, output int ack_at,
                          output logic [31:0] got_d, output logic got_e);
        tx_t  t;
        rsp_t r;
        int   t0;
        t.wr    = wr;
        t.addr  = a;
        t.data  = wr ? d : 32'h0;
        t.bsel  = b;
        t.rdata = d;
        t.err   = err;
        t.clr   = clr;
        r.wr    = wr;
        r.data  = (wr || err) ? 32'h0 : d;
        r.err   = !wr && err;
        exp_tx.push_back(t);
        exp_rsp.push_back(r);
        c_access  = 1'b1;
        c_wr_en   = wr;
        c_addr    = a;
        c_wr_val  = wr ? d : 32'h0;
        c_bytesel = b;
        t0     = cyc;
        ack_at = -1;
        got_d  = '0;
        got_e  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (c_ack) begin
                ack_at = cyc;
                got_d  = c_data;
                got_e  = c_error;
                break;
            end
        end
        c_access = 1'b0;
        c_wr_en  = 1'b0;
        if (ack_at < 0) fail("c_ack_timeout");
        lat_out = ack_at - t0;
    endtask

    task automatic wr(input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] b, input logic err,
                      input logic clr, output int l);
        int          at;
        logic [31:0] gd;
        logic        ge;
        do_req(1'b1, a, d, b, err, clr, l, at, gd, ge);
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wb_empty) break;
        end
        chk(nm, wb_empty, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int          l;
        int          at;
        int          a0;
        int          h0;
        int          ack5;
        logic [31:0] gd;
        logic        ge;

        rst_n     = 1'b0;
        c_access  = 1'b0;
        c_addr    = '0;
        c_wr_val  = '0;
        c_wr_en   = 1'b0;
        c_bytesel = '0;

        repeat (3) @(negedge clk);
        chk("reset_c_side", {c_ack, c_error, c_data}, 34'h0);
        chk("reset_m_side", {m_access, m_addr, m_wr_val, m_wr_en, m_bytesel}, 68'h0);
        chk("reset_status", {wb_empty, wb_error}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_wb_empty", wb_empty, 1'b1);

        // Single posted write, memory acks after 3 cycles.
        lat = 3;
        wr(30'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b0, l);
        chk("write_ack_latency", l, 1);
        wait_empty("single_write_empty");
        chk("single_write_addr", last_addr, 30'h0000_0100);
        chk("single_write_data", last_data, 32'hDEAD_BEEF);

        // Fill with memory stalled; fifth write waits for the first pop.
        lat   = 1;
        stall = 1'b1;
        a0    = ack_cnt;
        for (int i = 1; i <= 4; i++)
            wr(30'h10 + 30'(i), 32'hA000_0000 + 32'(i), 4'(i), 1'b0, 1'b0, l);
        @(negedge clk);
        chk("four_acks_while_stalled", ack_cnt - a0, 4);
        h0 = mack_q.size();
        fork
            begin
                wr(30'h15, 32'hA000_0005, 4'b0101, 1'b0, 1'b0, l);
                ack5 = cyc;
            end
            begin
                repeat (6) @(negedge clk);
                chk("fifth_stalled", ack_cnt - a0, 4);
                stall = 1'b0;
            end
        join
        chk("fifth_ack_after_first_mack", ack5 - mack_q[h0], 1);
        wait_empty("full_drain_empty");

        // Two writes then a read; the read must wait behind both.
        lat = 3;
        wr(30'h200, 32'h1111_1111, 4'b1111, 1'b0, 1'b0, l);
        wr(30'h201, 32'h2222_2222, 4'b0000, 1'b0, 1'b0, l);
        do_req(1'b0, 30'h40, 32'h1234_5678, 4'b1111, 1'b0, 1'b0, l, at, gd, ge);
        chk("read_data", gd, 32'h1234_5678);
        chk("read_error", ge, 1'b0);
        chk("read_ack_after_mack", at - rd_mack_cyc, 1);
        chk("after_read_empty", wb_empty, 1'b1);

        // Posted write error: sticky flag, no c_error, next entry drains.
        lat = 2;
        wr(30'h300, 32'hE0E0_E0E0, 4'b1111, 1'b1, 1'b0, l);
        wr(30'h301, 32'h0000_0301, 4'b0011, 1'b0, 1'b0, l);
        wait_empty("err_drain_empty");
        chk("wb_error_set", wb_error, 1'b1);
        chk("err_next_entry_drained", last_addr, 30'h301);
        clr_req++;
        repeat (2) @(negedge clk);
        chk("wb_error_cleared", wb_error, 1'b0);

        // Clear and new error in the same cycle: error wins.
        wr(30'h302, 32'h0000_0302, 4'b1000, 1'b1, 1'b1, l);
        wait_empty("clr_race_empty");
        chk("wb_error_set_wins", wb_error, 1'b1);
        clr_req++;
        repeat (2) @(negedge clk);
        chk("wb_error_cleared2", wb_error, 1'b0);

        // Read error.
        do_req(1'b0, 30'h80, 32'h5555_AAAA, 4'b1111, 1'b1, 1'b0, l, at, gd, ge);
        chk("read_err_c_error", ge, 1'b1);
        chk("read_err_c_data", gd, 32'h0);
        @(negedge clk);
        chk("read_err_one_cycle", {c_ack, c_error}, 2'b00);
        chk("read_err_no_wb_error", wb_error, 1'b0);

        // Mixed traffic with varying latency; wraps the pointers.
        for (int i = 0; i < 9; i++) begin
            lat = 1 + (i % 3);
            if (i % 3 == 2) begin
                do_req(1'b0, 30'h400 + 30'(i), 32'hC0DE_0000 + 32'(i),
                       4'(15 - i), 1'b0, 1'b0, l, at, gd, ge);
                chk("mix_read_data", gd, 32'hC0DE_0000 + 32'(i));
            end else begin
                wr(30'h500 + 30'(i), 32'h1000_0000 + 32'(i), 4'(i),
                   1'b0, 1'b0, l);
            end
        end
        wait_empty("mix_empty");

        // Reset with 3 entries buffered and one write in flight.
        lat   = 1;
        stall = 1'b1;
        for (int i = 0; i < 4; i++)
            wr(30'h600 + 30'(i), 32'h6000_0000 + 32'(i), 4'b1111, 1'b0, 1'b0, l);
        chk("pre_reset_m_access", m_access, 1'b1);
        chk("pre_reset_not_empty", wb_empty, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_c_side", {c_ack, c_error, c_data}, 34'h0);
        chk("async_reset_m_side", {m_access, m_addr, m_wr_val, m_wr_en, m_bytesel}, 68'h0);
        chk("async_reset_status", {wb_empty, wb_error}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_release_idle", {wb_empty, m_access}, 2'b10);
        end

        // Operation resumes after reset.
        wr(30'h700, 32'h7777_7777, 4'b1111, 1'b0, 1'b0, l);
        wait_empty("resume_empty");
        chk("resume_addr", last_addr, 30'h700);

        repeat (3) @(negedge clk);
        chk("all_tx_reached_memory", exp_tx.size() - exp_rd, 0);
        chk("all_rsp_seen", exp_rsp.size() - rsp_rd, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
